// File: rtl/osc_noise_poly_if.sv
// ---------------------------------------------------------------------------
// osc_noise_poly_if
//   Bundles the control inputs and mixed-sample outputs of the polyphonic
//   noise generator. The clock and reset stay plain ports on the modules.
//
//   tick     : one-cycle sample strobe (master -> slave)
//   en       : per-voice enable, one bit per voice
//   mode     : per-voice LFSR mode, 0 = long sequence, 1 = short sequence
//   period   : per-voice step divider, voice k at [k*PERIOD_W +: PERIOD_W]
//   volume   : per-voice unsigned amplitude, voice k at [k*VOL_W +: VOL_W]
//   sample   : signed mixed output (slave -> master)
//   valid    : one-cycle pulse when sample updates
//   busy     : high while a mix is in progress
//   overrun  : one-cycle pulse when a tick arrived during a mix
// ---------------------------------------------------------------------------
interface osc_noise_poly_if #(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 17,
  parameter int PERIOD_W = 16
);
  localparam int VOL_W = SAMPLE_W - 1;

  logic                         tick;
  logic [CHANNELS-1:0]          en;
  logic [CHANNELS-1:0]          mode;
  logic [CHANNELS*PERIOD_W-1:0] period;
  logic [CHANNELS*VOL_W-1:0]    volume;
  logic signed [SAMPLE_W-1:0]   sample;
  logic                         valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output tick, en, mode, period, volume,
    input  sample, valid, busy, overrun
  );

  modport slave (
    input  tick, en, mode, period, volume,
    output sample, valid, busy, overrun
  );
endinterface

// File: rtl/osc_noise_poly.sv
// ---------------------------------------------------------------------------
// osc_noise_poly
//   Polyphonic LFSR noise generator. Each tick starts a mix that walks the
//   voices one per clock: a voice's divider decides whether its 15-bit LFSR
//   steps, the post-step LFSR bit 0 picks +volume or -volume, and the sum is
//   clamped to the signed output range and presented with a valid pulse
//   CHANNELS+1 cycles after the tick.
//
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : osc_noise_poly_if.slave (tick, en, mode, period, volume in;
//          sample, valid, busy, overrun out)
// ---------------------------------------------------------------------------
module osc_noise_poly #(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 17,
  parameter int PERIOD_W = 16
) (
  input logic              clk,
  input logic              rst,
  osc_noise_poly_if.slave  bus
);

  localparam int VOL_W  = SAMPLE_W - 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Wide enough that CHANNELS full-scale contributions of either sign fit.
  localparam int ACC_W  = SAMPLE_W + $clog2(CHANNELS);
  localparam int LFSR_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic signed [ACC_W-1:0]   acc;
  logic [LFSR_W-1:0]         lfsr [CHANNELS];
  logic [PERIOD_W-1:0]       cnt  [CHANNELS];
  logic signed [SAMPLE_W-1:0] sample_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      overrun_q;

  // Datapath for the voice currently selected by ch.
  logic                      cur_en;
  logic                      cur_mode;
  logic [PERIOD_W-1:0]       cur_period;
  logic [VOL_W-1:0]          cur_vol;
  logic [LFSR_W-1:0]         cur_lfsr;
  logic [PERIOD_W-1:0]       cur_cnt;
  logic                      fb;
  logic                      step;
  logic [LFSR_W-1:0]         nxt_lfsr;
  logic [PERIOD_W-1:0]       nxt_cnt;
  logic signed [ACC_W-1:0]   vol_ext;
  logic signed [ACC_W-1:0]   contrib;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-SAMPLE_W:0]   upper;
  logic signed [SAMPLE_W-1:0] sat;
  logic                      last_ch;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    cur_en     = bus.en[ch];
    cur_mode   = bus.mode[ch];
    cur_period = bus.period[ch*PERIOD_W +: PERIOD_W];
    cur_vol    = bus.volume[ch*VOL_W +: VOL_W];
    cur_lfsr   = lfsr[ch];
    cur_cnt    = cnt[ch];

    fb       = cur_lfsr[0] ^ (cur_mode ? cur_lfsr[6] : cur_lfsr[1]);
    step     = cur_en && (cur_cnt == '0);
    // Each step is invertible (bit 0 can be recovered from fb), so a nonzero
    // register can never map to all-zero in either mode.
    nxt_lfsr = step ? {fb, cur_lfsr[LFSR_W-1:1]} : cur_lfsr;

    nxt_cnt = cur_cnt;
    if (cur_en) begin
      if (cur_cnt == '0) begin
        // Period 0 behaves as period 1: reload 0 so every tick steps.
        nxt_cnt = (cur_period == '0) ? '0 : cur_period - 1'b1;
      end else begin
        nxt_cnt = cur_cnt - 1'b1;
      end
    end

    vol_ext = $signed({{(ACC_W-VOL_W){1'b0}}, cur_vol});
    contrib = '0;
    if (cur_en) begin
      contrib = nxt_lfsr[0] ? -vol_ext : vol_ext;
    end
    acc_nxt = acc + contrib;

    // In range exactly when the bits above the output sign all match it.
    upper = acc_nxt[ACC_W-1:SAMPLE_W-1];
    if ((upper == '0) || (upper == '1)) begin
      sat = acc_nxt[SAMPLE_W-1:0];
    end else if (acc_nxt[ACC_W-1]) begin
      sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    last_ch = (ch == CH_W'(CHANNELS-1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ch        <= '0;
      acc       <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the voice arrays are reset too; an LFSR left unknown could power
      // up all-zero and lock, and the divider phase must start at 0 so the
      // first tick after reset steps every enabled voice.
      for (int i = 0; i < CHANNELS; i++) begin
        lfsr[i] <= LFSR_W'(1);
        cnt[i]  <= '0;
      end
    end else begin
      valid_q   <= 1'b0;
      // A tick during a mix is dropped; only the flag records it.
      overrun_q <= bus.tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.tick) begin
            state  <= RUN;
            ch     <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          lfsr[ch] <= nxt_lfsr;
          cnt[ch]  <= nxt_cnt;
          acc      <= acc_nxt;
          if (last_ch) begin
            // Output registers load on entry to DONE so valid is high for
            // exactly the DONE cycle.
            state    <= DONE;
            sample_q <= sat;
            valid_q  <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample  = sample_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_osc_noise_poly.sv
// ---------------------------------------------------------------------------
// tb_osc_noise_poly
//   Directed bench for osc_noise_poly (4 voices, 17-bit samples). Each tick
//   pushes its expected sample into a queue; a monitor pops and compares on
//   every valid pulse. Expected values come from hand-derived constants at the
//   points of interest and a tick-level voice model elsewhere.
// ---------------------------------------------------------------------------
module tb_osc_noise_poly;

  localparam int CH = 4;
  localparam int SW = 17;
  localparam int PW = 16;
  localparam int VW = SW - 1;

  typedef struct {
    string                  name;
    logic signed [SW-1:0]   value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  osc_noise_poly_if #(.CHANNELS(CH), .SAMPLE_W(SW), .PERIOD_W(PW)) bus ();

  osc_noise_poly #(.CHANNELS(CH), .SAMPLE_W(SW), .PERIOD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q [$];

  logic [14:0]   m_lfsr [CH];
  logic [PW-1:0] m_cnt  [CH];

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_lfsr[c] = 15'h0001;
      m_cnt[c]  = '0;
    end
  endtask

  // One full tick over all voices using the inputs currently on the bus.
  task automatic model_tick(output logic signed [SW-1:0] res);
    longint sum;
    longint lim;
    sum = 0;
    lim = longint'(1) << (SW - 1);
    for (int c = 0; c < CH; c++) begin
      logic [PW-1:0] p;
      logic [VW-1:0] v;
      logic          b;
      p = bus.period[c*PW +: PW];
      v = bus.volume[c*VW +: VW];
      if (bus.en[c]) begin
        if (m_cnt[c] == 0) begin
          b = m_lfsr[c][0] ^ (bus.mode[c] ? m_lfsr[c][6] : m_lfsr[c][1]);
          m_lfsr[c] = {b, m_lfsr[c][14:1]};
          m_cnt[c]  = (p == 0) ? '0 : p - 1;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
        sum += m_lfsr[c][0] ? -longint'(v) : longint'(v);
      end
    end
    if (sum > lim - 1) sum = lim - 1;
    if (sum < -lim)    sum = -lim;
    res = sum[SW-1:0];
  endtask

  task automatic set_voice(int k, bit e, bit m, int p, int v);
    bus.en[k]              = e;
    bus.mode[k]            = m;
    bus.period[k*PW +: PW] = p[PW-1:0];
    bus.volume[k*VW +: VW] = v[VW-1:0];
  endtask

  task automatic push_exp(string name, bit use_hand, int hand);
    logic signed [SW-1:0] m;
    exp_t e;
    model_tick(m);
    e.name  = name;
    e.value = use_hand ? SW'(hand) : m;
    exp_q.push_back(e);
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge at which
  // the DUT is idle again.
  task automatic fire(string name, bit use_hand, int hand);
    push_exp(name, use_hand, hand);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("valid with nothing pending", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, $signed(bus.sample), e.value);
        end
      end
    end
  endtask

  initial begin
    int lat;
    bus.tick   = 1'b0;
    bus.en     = '0;
    bus.mode   = '0;
    bus.period = '0;
    bus.volume = '0;
    model_reset();
    fork
      monitor();
    join_none

    // Reset state.
    #2;
    check("reset sample", $signed(bus.sample), 0);
    check("reset valid", bus.valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset overrun", bus.overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // First sample: voice 0 only, LFSR 0001 -> 4000, positive, 5-cycle latency.
    set_voice(0, 1, 0, 1, 16384);
    @(negedge clk);
    push_exp("first sample", 1, 16384);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("busy in run", bus.busy, 1);
    lat = 1;
    while (bus.valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("valid latency", lat, 5);
    check("busy in done", bus.busy, 1);
    @(negedge clk);
    check("valid one cycle", bus.valid, 0);
    check("busy after done", bus.busy, 0);

    // Short mode: LFSR back at 0001 after 93 steps, so tick 93 is negative
    // and tick 94 repeats tick 1.
    apply_reset();
    set_voice(0, 1, 1, 1, 16384);
    for (int i = 1; i <= 94; i++) begin
      fire($sformatf("short t%0d", i), (i == 1) || (i == 93),
           (i == 93) ? -16384 : 16384);
    end
    fire("short t95", 0, 0);

    // Long mode, period 0: first negative sample on step 15 = tick 15.
    apply_reset();
    set_voice(0, 1, 0, 0, 16384);
    for (int i = 1; i <= 20; i++) begin
      fire($sformatf("p0 t%0d", i), (i == 14) || (i == 15),
           (i == 15) ? -16384 : 16384);
    end

    // Long mode, period 4: steps on ticks 1,5,9,..., step 15 on tick 57.
    apply_reset();
    set_voice(0, 1, 0, 4, 16384);
    for (int i = 1; i <= 60; i++) begin
      fire($sformatf("p4 t%0d", i), (i == 56) || (i == 57) || (i == 60),
           (i >= 57) ? -16384 : 16384);
    end

    // Saturation: four identical voices at full volume.
    apply_reset();
    for (int k = 0; k < CH; k++) set_voice(k, 1, 0, 1, 32767);
    for (int i = 1; i <= 16; i++) begin
      fire($sformatf("sat t%0d", i), (i == 1) || (i == 14) || (i == 15),
           (i == 15) ? -65536 : 65535);
    end

    // Mixed modes, periods and volumes.
    set_voice(0, 1, 0, 1, 1000);
    set_voice(1, 1, 1, 2, 700);
    set_voice(2, 1, 0, 3, 3000);
    set_voice(3, 1, 1, 0, 50);
    for (int i = 1; i <= 24; i++) fire($sformatf("mix t%0d", i), 0, 0);

    // Voice 1 disabled for 10 ticks, then enabled: its first step is 0001->4000.
    apply_reset();
    set_voice(0, 1, 0, 1, 100);
    set_voice(1, 0, 0, 3, 2000);
    set_voice(2, 1, 0, 1, 300);
    set_voice(3, 1, 0, 1, 40);
    for (int i = 1; i <= 10; i++) fire($sformatf("dis t%0d", i), 1, 440);
    set_voice(1, 1, 0, 3, 2000);
    fire("dis t11", 1, 2440);
    for (int i = 12; i <= 17; i++) fire($sformatf("dis t%0d", i), 0, 0);

    // Overrun: second tick two cycles into a mix is ignored.
    push_exp("overrun pair", 0, 0);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("overrun pulse", bus.overrun, 1);
    check("busy at overrun", bus.busy, 1);
    @(negedge clk);
    check("overrun one cycle", bus.overrun, 0);
    repeat (2) @(negedge clk);
    fire("after overrun", 0, 0);

    // Async reset during ch=2: outputs clear with no clock edge, no valid.
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort sample", $signed(bus.sample), 0);
    check("abort busy", bus.busy, 0);
    check("abort valid", bus.valid, 0);
    check("abort overrun", bus.overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (8) @(negedge clk);
    for (int k = 0; k < CH; k++) set_voice(k, 1, 0, 1, 1000);
    for (int i = 1; i <= 15; i++) begin
      fire($sformatf("post-reset t%0d", i), (i == 1) || (i == 15),
           (i == 15) ? -4000 : 4000);
    end

    repeat (10) @(negedge clk);
    check("pending expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osc_noise_poly.md
OSC_NOISE_POLY -- requirements
Module: osc_noise_poly

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of noise voices (1..16).
REQ-002 SHALL have parameter SAMPLE_W, default 17, signed output sample width; volume width VOL_W = SAMPLE_W-1.
REQ-003 SHALL have parameter PERIOD_W, default 16, per-voice step divider width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick  in  1  one-cycle sample strobe (e.g. 44.1 kHz rate).
REQ-007 SHALL have port en  in  CHANNELS  per-voice enable.
REQ-008 SHALL have port mode  in  CHANNELS  per-voice LFSR mode (0 long, 1 short).
REQ-009 SHALL have port period  in  CHANNELS*PERIOD_W  per-voice divider, voice k at bits [k*PERIOD_W +: PERIOD_W].
REQ-010 SHALL have port volume  in  CHANNELS*VOL_W  per-voice unsigned amplitude, same packing.
REQ-011 SHALL have port sample  out  SAMPLE_W  signed mixed output, registered.
REQ-012 SHALL have port valid  out  1  one-cycle pulse when sample updates.
REQ-013 SHALL have port busy  out  1  high while a mix is in progress.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse when tick arrives while busy.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy high in RUN and DONE.
REQ-016 IDLE: tick=1 -> RUN, channel index ch=0, accumulator acc=0; tick=0 -> stay.
REQ-017 RUN: one voice per cycle, ch increments; after ch=CHANNELS-1 -> DONE.
REQ-018 DONE: sample <= saturated acc, valid=1 for that cycle, -> IDLE; valid asserted exactly CHANNELS+1 cycles after the tick cycle.
REQ-019 Each voice SHALL own a 15-bit LFSR and a PERIOD_W-bit down-counter.
REQ-020 Voice processing when en[ch]=1: counter==0 -> step LFSR, counter <= max(period-1,0); else counter <= counter-1; period P (P=0 treated as 1) steps once every P ticks, first step on first tick after reset.
REQ-021 LFSR step: fb = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]); lfsr <= {fb, lfsr[14:1]}; mode sampled at the step.
REQ-022 Voice contribution uses post-step LFSR: lfsr[0]==0 -> +volume, 1 -> -volume, sign-extended into acc.
REQ-023 en[ch]=0: LFSR and counter hold, contribution 0.
REQ-024 acc width SAMPLE_W+clog2(CHANNELS) SHALL never overflow; final value clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-025 en, mode, period, volume for voice ch SHALL be sampled in that voice's RUN cycle.
REQ-026 tick in RUN or DONE SHALL be ignored (no restart, no state change) and pulse overrun next cycle.
REQ-027 LFSR SHALL never reach all-zero from any reachable state.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, sample 0, valid 0, busy 0, overrun 0, acc 0, ch 0.
REQ-029 rst=0 SHALL set every LFSR to 15'h0001 and every counter to 0.
REQ-030 rst asserted mid-RUN SHALL abort the mix with no valid pulse; first tick after release starts a fresh mix.

Verification
REQ-031 Reset/first sample: CHANNELS=4, only voice 0 en, mode 0, period 1, volume 16384, one tick -> LFSR0 = 15'h4000, valid 5 cycles later, sample = +16384.
REQ-032 Sequence length: one voice, period 1, mode 0 -> LFSR returns to 15'h0001 after exactly 32767 ticks; mode 1 -> after exactly 93 ticks.
REQ-033 Divider: period 4 -> LFSR steps on ticks 1, 5, 9, 13 only; period 0 behaves identically to period 1.
REQ-034 Saturation: 4 voices en, period 1, volume 32767, identical state -> first sample +65535 (sum 131068 clamped); a tick where all lfsr[0]=1 -> -65536.
REQ-035 Disable/overrun: voice 1 disabled for 10 ticks -> its LFSR and counter unchanged, contribution 0; tick pulsed 2 cycles after a tick -> overrun=1 one cycle, exactly one valid for the pair.
REQ-036 Async reset mid-RUN: rst low for one cycle during ch=2 -> sample 0, busy 0 with no clock edge required, no valid pulse, LFSRs at 15'h0001.
